// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage divider: FSM states, ready/start levels,
// reset level and the zero word used on the HI/LO write path.
// Combinational constants only; no latency, no backpressure.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_t;

   localparam logic        DivResultReady    = 1'b1;
   localparam logic        DivResultNotReady = 1'b0;
   localparam logic        DivStart          = 1'b1;
   localparam logic        DivStop           = 1'b0;
   localparam logic        RstEna            = 1'b1;
   localparam logic [31:0] ZeroWord          = 32'h0000_0000;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU, one trial subtraction per cycle.
// Latency: ready_o rises 34 cycles after start_i is taken (2 cycles for divide by zero).
// Backpressure: result and ready_o are held in DivEnd until EX drops start_i.
//
// Ports: clk, rst (sync, active high); signed_div_i selects DIV vs DIVU;
// opdata1_i dividend, opdata2_i divisor; start_i request (held until ready_o);
// annul_i cancels an in-flight divide; result_o = {remainder, quotient}; ready_o.
// Optional macro DIV_SIGNED_EN compiles in the signed path; without it every
// divide is unsigned and signed_div_i is ignored.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam int CW = $clog2(WIDTH) + 1;

   div_state_t         state;
   logic [2*WIDTH:0]   dividend;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   divisor;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   op1_mag;
   logic [WIDTH-1:0]   op2_mag;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Trial subtraction of the divisor from the current partial remainder;
   // the extra top bit is the borrow that says the subtraction does not fit.
   assign diff = {1'b0, dividend[2*WIDTH-1:WIDTH]} - {1'b0, divisor};

`ifdef DIV_SIGNED_EN
   // Signs are captured when the divide is accepted so a late change on the
   // operand buses cannot corrupt the final correction.
   logic neg_quo;
   logic neg_rem;

   assign op1_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign op2_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
   assign quo_fix = neg_quo ? -dividend[WIDTH-1:0] : dividend[WIDTH-1:0];
   assign rem_fix = neg_rem ? -dividend[2*WIDTH:WIDTH+1] : dividend[2*WIDTH:WIDTH+1];

   always_ff @(posedge clk) begin
      if (rst == RstEna) begin
         neg_quo <= 1'b0;
         neg_rem <= 1'b0;
      end else if (state == DivFree && start_i == DivStart && !annul_i) begin
         neg_quo <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
         neg_rem <= signed_div_i && opdata1_i[WIDTH-1];
      end
   end
`else
   logic unused_signed_div;

   assign unused_signed_div = signed_div_i;
   assign op1_mag = opdata1_i;
   assign op2_mag = opdata2_i;
   assign quo_fix = dividend[WIDTH-1:0];
   assign rem_fix = dividend[2*WIDTH:WIDTH+1];
`endif

   always_ff @(posedge clk) begin
      if (rst == RstEna) begin
         state    <= DivFree;
         cnt      <= '0;
         dividend <= '0;
         divisor  <= '0;
         result_o <= '0;
         ready_o  <= DivResultNotReady;
      end else begin
         case (state)
            DivFree: begin
               if (start_i == DivStart && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state <= DivByZero;
                  end else begin
                     state    <= DivOn;
                     cnt      <= '0;
                     divisor  <= op2_mag;
                     dividend <= {{WIDTH{1'b0}}, op1_mag, 1'b0};
                  end
               end
            end
            DivByZero: begin
               if (annul_i) begin
                  state <= DivFree;
               end else begin
                  result_o <= {ZeroWord, ZeroWord};
                  ready_o  <= DivResultReady;
                  state    <= DivEnd;
               end
            end
            DivOn: begin
               if (annul_i) begin
                  state <= DivFree;
                  cnt   <= '0;
               end else if (cnt != CW'(WIDTH)) begin
                  // Quotient bits enter at the bottom while the partial
                  // remainder climbs the upper half of the working register.
                  if (diff[WIDTH]) begin
                     dividend <= {dividend[2*WIDTH-1:0], 1'b0};
                  end else begin
                     dividend <= {diff[WIDTH-1:0], dividend[WIDTH-1:0], 1'b1};
                  end
                  cnt <= cnt + 1'b1;
               end else begin
                  result_o <= {rem_fix, quo_fix};
                  ready_o  <= DivResultReady;
                  state    <= DivEnd;
                  cnt      <= '0;
               end
            end
            DivEnd: begin
               if (start_i == DivStop) begin
                  state    <= DivFree;
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
               end
            end
            default: state <= DivFree;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a cycle-level expectation of ready/result is
// maintained by the stimulus and compared every cycle, plus literal results
// and measured latencies for the hand-computed vectors.
module tb_div_unit;

`ifdef DIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        signed_div_i = 1'b0;
   logic [31:0] opdata1_i = '0;
   logic [31:0] opdata2_i = '0;
   logic        start_i = 1'b0;
   logic        annul_i = 1'b0;
   logic [63:0] result_o;
   logic        ready_o;

   div_unit #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   // Expected outputs for the current cycle, written by the stimulus only.
   bit          chk_en = 1'b0;
   logic        m_ready = 1'b0;
   logic [63:0] m_result = '0;
   bit          lit_en = 1'b0;
   logic [63:0] lit_exp = '0;
   string       lit_name = "";
   bit          lat_en = 1'b0;
   int          lat_got = 0;
   int          lat_exp = 0;

   int checks = 0;
   int failures = 0;

   // Reference arithmetic: MIPS semantics are C-style truncating division,
   // which the 64-bit signed operators give directly.
   function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                             input bit sgn);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (SIGNED_EN && sgn) begin
         sa = longint'(signed'(a));
         sb = longint'(signed'(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (ready_o !== m_ready || result_o !== (m_ready ? m_result : 64'd0)) begin
            failures++;
            $display("FAIL cycle t=%0t ready=%b result=%h expected ready=%b result=%h",
                     $time, ready_o, result_o, m_ready, m_ready ? m_result : 64'd0);
         end
         if (lit_en) begin
            checks++;
            if (result_o !== lit_exp) begin
               failures++;
               $display("FAIL %s result=%h expected=%h", lit_name, result_o, lit_exp);
            end
         end
         if (lat_en) begin
            checks++;
            if (lat_got != lat_exp) begin
               failures++;
               $display("FAIL %s latency=%0d expected=%0d", lit_name, lat_got, lat_exp);
            end
         end
      end
   end

   // One divide request. annul_at / rst_at (cycles after acceptance, 0 = none)
   // cancel the divide; otherwise start_i is held one extra cycle after ready_o
   // to check the hold behaviour, then dropped.
   task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input bit sgn, input int annul_at, input int rst_at,
                          input logic [63:0] lit);
      logic [63:0] exp;
      int lat, seen, stop_k;
      bit aborted;
      exp      = model_div(a, b, sgn);
      lat      = (b == 32'd0) ? 2 : 34;
      seen     = -1;
      aborted  = 1'b0;
      stop_k   = lat + 2;
      lit_name = name;
      lit_exp  = lit;
      opdata1_i    = a;
      opdata2_i    = b;
      signed_div_i = sgn;
      start_i      = 1'b1;
      for (int k = 1; k <= stop_k; k++) begin
         @(posedge clk);
         #1;
         lit_en  = 1'b0;
         annul_i = 1'b0;
         rst     = 1'b0;
         if (ready_o === 1'b1 && seen < 0) seen = k;
         if (k == annul_at) begin
            annul_i = 1'b1;
            start_i = 1'b0;
            aborted = 1'b1;
            stop_k  = k + 3;
         end
         if (k == rst_at) begin
            rst     = 1'b1;
            start_i = 1'b0;
            aborted = 1'b1;
            stop_k  = k + 3;
         end
         if (!aborted) begin
            if (k == lat) begin
               m_ready  = 1'b1;
               m_result = exp;
               lit_en   = 1'b1;
            end
            if (k == lat + 1) start_i = 1'b0;
            if (k == lat + 2) m_ready = 1'b0;
         end
      end
      lat_got = seen;
      lat_exp = aborted ? -1 : lat;
      lat_en  = 1'b1;
      @(posedge clk);
      #1;
      lat_en = 1'b0;
   endtask

   initial begin
      repeat (1) @(posedge clk);
      #1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      run_div("udiv_100_7", 32'd100, 32'd7, 1'b0, 0, 0, {32'd2, 32'd14});
      run_div("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0,
              SIGNED_EN ? {32'hFFFF_FFFF, 32'hFFFF_FFFD} : {32'd1, 32'h7FFF_FFFC});
      run_div("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0, 0,
              SIGNED_EN ? {32'd1, 32'hFFFF_FFFD} : {32'd7, 32'd0});
      run_div("div_by_zero", 32'h1234, 32'd0, 1'b0, 0, 0, 64'd0);
      run_div("sdiv_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0,
              SIGNED_EN ? {32'd0, 32'h8000_0000} : {32'h8000_0000, 32'd0});
      run_div("udiv_7_100", 32'd7, 32'd100, 1'b0, 0, 0, {32'd7, 32'd0});
      run_div("annul_mid", 32'd1000, 32'd3, 1'b0, 10, 0, 64'd0);
      run_div("udiv_9_3", 32'd9, 32'd3, 1'b0, 0, 0, {32'd0, 32'd3});
      run_div("annul_dbz", 32'd5, 32'd0, 1'b0, 1, 0, 64'd0);
      run_div("rst_mid", 32'd12345, 32'd67, 1'b0, 0, 20, 64'd0);
      run_div("udiv_max_64k", 32'hFFFF_FFFF, 32'h0001_0000, 1'b0, 0, 0,
              {32'h0000_FFFF, 32'h0000_FFFF});

      // start_i together with annul_i must not launch a divide.
      opdata1_i = 32'd50;
      opdata2_i = 32'd5;
      start_i   = 1'b1;
      annul_i   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start_i = 1'b0;
      annul_i = 1'b0;
      repeat (38) @(posedge clk);
      #1;

      run_div("udiv_after_ignore", 32'd50, 32'd5, 1'b0, 0, 0, {32'd0, 32'd10});

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
